// File: rtl/cpu_alu_sched_pkg.sv
// Shared types and constants for the ALU scheduler and its datapath.
// Latency: n/a (types, constants, pure function only).
// Backpressure: n/a.
package cpu_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MULW = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic of;
    logic cf;
    logic zf;
    logic nf;
  } alu_flags_t;

  localparam logic [7:0] OP_ADD = 8'h10;
  localparam logic [7:0] OP_SUB = 8'h12;
  localparam logic [7:0] OP_MUL = 8'h14;
  localparam logic [7:0] OP_SHL = 8'h20;

  // Multiplies are recognised by opcode class bits, not by exact opcode.
  function automatic logic is_mul(input logic [7:0] op);
    return op[4] & op[2];
  endfunction

endpackage

// File: rtl/cpu_alu_sched_if.sv
// Requester-side bundle for the shared ALU: per-requester issue + response strobe.
// Latency: n/a (wiring only).
// Backpressure: issue via valid/ready per requester; responses are not backpressured.
interface cpu_alu_sched_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*8-1:0]  req_op;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_data;
  logic [3:0]            rsp_flags;

  modport master (
    output req_valid, req_a, req_b, req_op,
    input  req_ready, rsp_valid, rsp_data, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    output req_ready, rsp_valid, rsp_data, rsp_flags
  );
endinterface

// File: rtl/cpu_alu.sv
// Combinational 32-bit ALU with per-flag update enables.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module cpu_alu
  import cpu_alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [7:0]  op,
  output logic [31:0] out,
  output logic        of,
  output logic        cf,
  output logic        zf,
  output logic        nf,
  output logic        of_en,
  output logic        cf_en,
  output logic        zf_en,
  output logic        nf_en
);
  logic [32:0] wide;

  // Result and flag generation; shifts leave every flag untouched, multiply only Z/N.
  always_comb begin
    wide  = '0;
    out   = '0;
    of    = 1'b0;
    cf    = 1'b0;
    of_en = 1'b0;
    cf_en = 1'b0;
    zf_en = 1'b0;
    nf_en = 1'b0;
    case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        out   = wide[31:0];
        cf    = wide[32];
        of    = (a[31] == b[31]) && (out[31] != a[31]);
        {of_en, cf_en, zf_en, nf_en} = 4'b1111;
      end
      OP_SUB: begin
        wide  = {1'b0, a} - {1'b0, b};
        out   = wide[31:0];
        cf    = wide[32];
        of    = (a[31] != b[31]) && (out[31] != a[31]);
        {of_en, cf_en, zf_en, nf_en} = 4'b1111;
      end
      OP_MUL: begin
        out   = a * b;
        zf_en = 1'b1;
        nf_en = 1'b1;
      end
      OP_SHL: begin
        out = a << b[4:0];
      end
      default: ;
    endcase
    zf = (out == 32'd0);
    nf = out[31];
  end
endmodule

// File: rtl/cpu_alu_sched_arb.sv
// Round-robin grant: first valid requester at or after the pointer, wrapping.
// Latency: 0 cycles (combinational).
// Backpressure: none; caller decides whether the grant is honoured.
module cpu_alu_rr_arb #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);
  int idx;

  // Scan from farthest to nearest so the nearest valid requester wins last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
    gnt = gnt_vld ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  end
endmodule

// File: rtl/cpu_alu_sched.sv
// Round-robin issue of requester ops onto one shared ALU, with per-requester flag contexts.
// Latency: accept at T -> rsp at T+2 (non-mul) or T+2+MUL_LAT (mul).
// Backpressure: req_ready drops while a multiply is held; responses cannot be stalled.
module cpu_alu_sched
  import cpu_alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MUL_LAT = 2
) (
  input logic            clk,
  input logic            rst,
  cpu_alu_sched_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);

  alu_state_e         state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      id_q, id_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [7:0]         op_q, op_d;
  logic [2:0]         cnt_q, cnt_d;
  alu_flags_t         flags_q [NUM_REQ];
  alu_flags_t         flags_d [NUM_REQ];
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  alu_flags_t         rsp_flags_q, rsp_flags_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_vld;
  logic               accept_ok;
  logic               capture;
  alu_flags_t         upd;

  logic [31:0] alu_out;
  logic        alu_of, alu_cf, alu_zf, alu_nf;
  logic        alu_of_en, alu_cf_en, alu_zf_en, alu_nf_en;

  cpu_alu_rr_arb #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  cpu_alu u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .out   (alu_out),
    .of    (alu_of),
    .cf    (alu_cf),
    .zf    (alu_zf),
    .nf    (alu_nf),
    .of_en (alu_of_en),
    .cf_en (alu_cf_en),
    .zf_en (alu_zf_en),
    .nf_en (alu_nf_en)
  );

  // Ready is the arbiter grant whenever the FSM can take a new op this cycle.
  assign bus.req_ready = (accept_ok && !rst) ? gnt : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flags = rsp_flags_q;

  // Next-state: FSM step, result capture into the owner's flag context, then new accept.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    flags_d     = flags_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    accept_ok   = 1'b0;
    capture     = 1'b0;
    upd         = '0;

    case (state_q)
      IDLE: accept_ok = 1'b1;
      EXEC: begin
        if (!is_mul(op_q) || MUL_LAT == 0) begin
          capture   = 1'b1;
          accept_ok = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d   = 3'((MUL_LAT > 0) ? MUL_LAT - 1 : 0);
          state_d = MULW;
        end
      end
      MULW: begin
        if (cnt_q == 3'd0) begin
          capture = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      upd.of          = alu_of_en ? alu_of : flags_q[id_q].of;
      upd.cf          = alu_cf_en ? alu_cf : flags_q[id_q].cf;
      upd.zf          = alu_zf_en ? alu_zf : flags_q[id_q].zf;
      upd.nf          = alu_nf_en ? alu_nf : flags_q[id_q].nf;
      flags_d[id_q]   = upd;
      rsp_data_d      = alu_out;
      rsp_valid_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << id_q;
      rsp_flags_d     = upd;
    end

    if (accept_ok && gnt_vld) begin
      a_d      = bus.req_a[32*gnt_idx +: 32];
      b_d      = bus.req_b[32*gnt_idx +: 32];
      op_d     = bus.req_op[8*gnt_idx +: 8];
      id_d     = gnt_idx;
      state_d  = EXEC;
      rr_ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  // All scheduler state; reset discards any in-flight op without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) flags_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      flags_q     <= flags_d;
    end
  end
endmodule
